// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between NUM_REQ producers.
// A granted producer keeps the port for up to MAX_BURST words; one idle cycle per arbitration.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in
);

    localparam int unsigned OwnW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [OwnW-1:0]      last_owner_q, last_owner_d;
    logic [BeatW-1:0]     beat_q, beat_d;

    logic                 xfer;
    logic                 owner_req;
    logic [OwnW-1:0]      next_owner;
    logic [OwnW-1:0]      hi_idx, lo_idx;
    logic                 hi_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_owner_q <= OwnW'(NUM_REQ - 1);
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
        end
    end

    // Lowest requester above last_owner wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = OwnW'(i);
                if (OwnW'(i) > last_owner_q) begin
                    hi_idx   = OwnW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        next_owner = hi_found ? hi_idx : lo_idx;
    end

    assign owner_req = req[last_owner_q];
    assign xfer      = (state_q == StBurst) && owner_req && !fifo_full;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d      = StBurst;
                    grant_d      = NUM_REQ'(1) << next_owner;
                    last_owner_d = next_owner;
                    beat_d       = '0;
                end
            end
            StBurst: begin
                if ((xfer && (beat_q == BeatW'(MAX_BURST - 1))) || !owner_req) begin
                    state_d = StIdle;
                    grant_d = '0;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + BeatW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ack      = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == StBurst) && (OwnW'(i) == last_owner_q)) begin
                req_ack[i]   = xfer;
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == StBurst);
    assign fifo_wr_en = xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: scripted producers, per-cycle expected traces.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        busy;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;

    int          nvec = 0;
    int          nerr = 0;
    int          left [4];
    logic [7:0]  word [4];
    logic [7:0]  wr_log [$];

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .grant        (grant),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, nvec=%0d required to finish", nvec);
        $fatal(1);
    end

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req[i]           = (left[i] > 0);
            req_data[i*8 +: 8] = word[i];
        end
    endtask

    // Sample outputs at negedge, then advance producers on the acks seen before the edge.
    task automatic cycle(output logic [3:0] g, output logic we, output logic [7:0] d,
                         output logic [3:0] ack);
        @(negedge clk);
        g   = grant;
        we  = fifo_wr_en;
        d   = fifo_data_in;
        ack = req_ack;
        if (we) wr_log.push_back(d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                left[i] = left[i] - 1;
                word[i] = word[i] + 8'd1;
            end
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            left[i] = 0;
            word[i] = 8'h00;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic test_reset();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        rst       = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            left[i] = 100;
            word[i] = 8'hA0 + 8'(i);
        end
        drive_inputs();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cycle(g, we, d, ack);
            nvec++;
            if (g !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_grant c%0d: got %b want 0000", k, g);
            end
            nvec++;
            if (we !== 1'b0 || ack !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_wr c%0d: we=%b ack=%b want 0 0000", k, we, ack);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        logic [3:0] exp_g  [10] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        logic       exp_we [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        apply_reset();
        left[2] = 6;
        word[2] = 8'd10;
        drive_inputs();
        for (int k = 0; k < 10; k++) begin
            cycle(g, we, d, ack);
            nvec++;
            if (g !== exp_g[k] || we !== exp_we[k]) begin
                nerr++;
                $display("FAIL single c%0d: grant=%b we=%b want %b %b", k, g, we, exp_g[k],
                         exp_we[k]);
            end
        end
        nvec++;
        if (wr_log.size() != 6) begin
            nerr++;
            $display("FAIL single_count: got %0d writes want 6", wr_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                nvec++;
                if (wr_log[i] !== 8'(10 + i)) begin
                    nerr++;
                    $display("FAIL single_data[%0d]: got %0d want %0d", i, wr_log[i], 10 + i);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        logic [3:0] eg;
        logic       ewe;
        logic [7:0] ed;
        int         gi, o, nth;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            left[i] = 100;
            word[i] = 8'((i + 1) * 16);
        end
        drive_inputs();
        for (int k = 0; k < 25; k++) begin
            cycle(g, we, d, ack);
            gi  = k / 5;
            o   = gi % 4;
            nth = (gi / 4) * 4 + (k % 5) - 1;
            ewe = (k % 5) != 0;
            eg  = ewe ? (4'b0001 << o) : 4'b0000;
            ed  = 8'((o + 1) * 16 + nth);
            nvec++;
            if (g !== eg || we !== ewe || (ewe && d !== ed) || ack !== (ewe ? eg : 4'b0000))
            begin
                nerr++;
                $display("FAIL rr c%0d: grant=%b we=%b data=%h ack=%b want %b %b %h %b", k, g,
                         we, d, ack, eg, ewe, ed, ewe ? eg : 4'b0000);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        logic       full_t [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic [3:0] exp_g  [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        logic       exp_we [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        apply_reset();
        left[0] = 6;
        word[0] = 8'h40;
        drive_inputs();
        for (int k = 0; k < 9; k++) begin
            fifo_full = full_t[k];
            cycle(g, we, d, ack);
            nvec++;
            if (g !== exp_g[k] || we !== exp_we[k] || ack !== (exp_we[k] ? 4'b0001 : 4'b0000))
            begin
                nerr++;
                $display("FAIL stall c%0d: grant=%b we=%b ack=%b want %b %b", k, g, we, ack,
                         exp_g[k], exp_we[k]);
            end
        end
        fifo_full = 1'b0;
        nvec++;
        if (wr_log.size() != 4 || wr_log[0] !== 8'h40 || wr_log[1] !== 8'h41 ||
            wr_log[2] !== 8'h42 || wr_log[3] !== 8'h43) begin
            nerr++;
            $display("FAIL stall_data: got %0d writes want 40 41 42 43", wr_log.size());
        end
    endtask

    task automatic test_drop_req();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        logic [3:0] exp_g  [6] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8};
        logic       exp_we [6] = '{0, 1, 1, 0, 0, 1};
        logic [7:0] exp_d  [6] = '{8'h00, 8'h50, 8'h51, 8'h00, 8'h00, 8'h70};
        apply_reset();
        left[1] = 2;
        word[1] = 8'h50;
        left[3] = 4;
        word[3] = 8'h70;
        drive_inputs();
        for (int k = 0; k < 6; k++) begin
            cycle(g, we, d, ack);
            nvec++;
            if (g !== exp_g[k] || we !== exp_we[k] || (exp_we[k] && d !== exp_d[k])) begin
                nerr++;
                $display("FAIL drop c%0d: grant=%b we=%b data=%h want %b %b %h", k, g, we, d,
                         exp_g[k], exp_we[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] g, ack;
        logic       we;
        logic [7:0] d;
        apply_reset();
        left[2] = 100;
        word[2] = 8'h60;
        drive_inputs();
        cycle(g, we, d, ack);
        cycle(g, we, d, ack);
        cycle(g, we, d, ack);
        nvec++;
        if (g !== 4'b0100 || d !== 8'h61) begin
            nerr++;
            $display("FAIL midrst_pre: grant=%b data=%h want 0100 61", g, d);
        end
        rst = 1'b1;
        cycle(g, we, d, ack);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            left[i] = 100;
            word[i] = 8'h01 + 8'(i * 16);
        end
        drive_inputs();
        cycle(g, we, d, ack);
        nvec++;
        if (g !== 4'b0000 || we !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_idle: grant=%b we=%b want 0000 0", g, we);
        end
        cycle(g, we, d, ack);
        nvec++;
        if (g !== 4'b0001 || we !== 1'b1 || d !== 8'h01) begin
            nerr++;
            $display("FAIL midrst_regrant: grant=%b we=%b data=%h want 0001 1 01", g, we, d);
        end
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        req       = '0;
        req_data  = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_drop_req();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
